awg_seq_ctrl: RTL
=================

AWG_SEQ_CTRL -- requirements
Module: awg_seq_ctrl

Interface
REQ-001 Parameter SEGS, default 8: number of sequence table entries; power of two.
REQ-002 Parameter FTW_W, default 14: frequency tuning word width, matching the DAC data width.
REQ-003 Parameter DWELL_W, default 24: dwell counter width, in clk cycles.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  log2(SEGS)  table entry index.
- cfg_wave  in  2  waveform code: 0 saw, 1 triangle, 2 square, 3 mute.
- cfg_ftw  in  FTW_W  tuning word for the entry.
- cfg_dwell  in  DWELL_W  segment duration, in cycles.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- start  in  1  start pulse.
- stop  in  1  abort pulse.
- last_seg  in  log2(SEGS)  index of the final segment.
- loop_en  in  1  wrap to segment 0 instead of finishing.
- wave_sel  out  2  waveform select to the DDS datapath.
- ftw  out  FTW_W  phase increment to the DDS datapath.
- seg_strobe  out  1  one-cycle pulse on each segment load (downstream phase clear).
- seg_idx  out  log2(SEGS)  active segment index.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse at sequence completion.

Function
REQ-005 The FSM SHALL have two states: IDLE and RUN.
REQ-006 In IDLE, wave_sel SHALL be 3, ftw 0, and running 0.
REQ-007 In IDLE, start=1 with stop=0 SHALL enter RUN next cycle.
- Entry 0 is loaded into wave_sel/ftw.
- seg_idx=0, seg_strobe=1.
- last_seg and loop_en are latched.
REQ-008 A segment with dwell D SHALL stay active exactly max(D,1) cycles.
- The dwell counter loads max(D,1)-1 and decrements each RUN cycle.
REQ-009 When the counter reaches 0 in RUN and seg_idx is not the latched last_seg, the block SHALL load entry seg_idx+1 next cycle and pulse seg_strobe.
REQ-010 When the counter reaches 0 at the latched last_seg with loop_en=1, the block SHALL load entry 0 next cycle and pulse seg_strobe.
- seg_idx wraps modulo SEGS.
REQ-011 When the counter reaches 0 at the latched last_seg with loop_en=0, the block SHALL go to IDLE next cycle.
- done pulses 1 for that cycle.
- Outputs return to mute values.
REQ-012 stop=1 in RUN SHALL force IDLE next cycle with done=0.
- stop has priority over segment advance and completion.
REQ-013 start SHALL be ignored in RUN.
REQ-014 start and stop asserted together in IDLE SHALL leave the block in IDLE.
REQ-015 cfg_we in IDLE SHALL write all three fields of entry cfg_addr at the clock edge.
REQ-016 cfg_we in RUN SHALL NOT modify the table and SHALL pulse cfg_err next cycle.
REQ-017 All outputs SHALL be registered, and segment transitions SHALL leave no gap cycle: new values appear on the cycle after the counter reaches 0.

Reset
REQ-018 rst SHALL override all other inputs, including mid-sequence.
REQ-019 On reset, the state SHALL be IDLE and outputs SHALL take these values:
- wave_sel=3, ftw=0, seg_idx=0.
- seg_strobe=0, running=0, done=0, cfg_err=0.
REQ-020 On reset, every table entry SHALL be cleared to wave 3, ftw 0, dwell 0.

Structure
REQ-021 A shared package SHALL hold the waveform code constants (WAVE_SAW, WAVE_TRI, WAVE_SQR, WAVE_MUTE) and the FSM state encoding.
REQ-022 The table SHALL be a sub-module, awg_seg_table: SEGS x (2+FTW_W+DWELL_W) registers, one write port, one combinational read port.
- The FSM and dwell counter stay in awg_seq_ctrl.

Verification
REQ-023 Basic sequence: program entry0={saw,100,5} and entry1={tri,200,3}; last_seg=1, loop_en=0; pulse start.
- ftw reads 100 for 5 cycles, then 200 for 3 cycles.
- seg_strobe pulses twice; done pulses once; the block returns to mute.
REQ-024 Loop mode: the same table with loop_en=1 for 20 cycles.
- ftw pattern 100x5, 200x3 repeats.
- seg_idx sequence 0,1,0,1...; done never asserts.
REQ-025 Abort: stop on cycle 2 of entry1.
- Next cycle: wave_sel=3, ftw=0, running=0, done=0.
REQ-026 Zero dwell: entry0 dwell=0, last_seg=0.
- The segment lasts exactly 1 cycle, followed by a done pulse.
REQ-027 Write while running: cfg_we to entry1 during RUN.
- cfg_err pulses; the readback sequence is unchanged.
- Simultaneous start+stop in IDLE leaves running=0.
REQ-028 Reset mid-run: rst asserted during segment 1.
- The next cycle shows the full reset values.
- A subsequent start with no reprogramming yields wave_sel=3, ftw=0, for 1 cycle.

Source files
------------

// File: rtl/awg_seq_ctrl_pkg.sv
// Shared waveform codes and sequencer state encoding for the AWG sequence controller.
package awg_seq_ctrl_pkg;

  localparam logic [1:0] WAVE_SAW  = 2'd0;
  localparam logic [1:0] WAVE_TRI  = 2'd1;
  localparam logic [1:0] WAVE_SQR  = 2'd2;
  localparam logic [1:0] WAVE_MUTE = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/awg_seg_table.sv
// Segment table: SEGS entries of {wave, ftw, dwell}, one synchronous write port and
// one combinational read port; synchronous reset clears every entry to a muted zero-length segment.
module awg_seg_table
  import awg_seq_ctrl_pkg::*;
#(
  parameter int SEGS    = 8,
  parameter int FTW_W   = 14,
  parameter int DWELL_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(SEGS)-1:0]  waddr,
  input  logic [1:0]               wdat_wave,
  input  logic [FTW_W-1:0]         wdat_ftw,
  input  logic [DWELL_W-1:0]       wdat_dwell,
  input  logic [$clog2(SEGS)-1:0]  raddr,
  output logic [1:0]               rd_wave,
  output logic [FTW_W-1:0]         rd_ftw,
  output logic [DWELL_W-1:0]       rd_dwell
);

  logic [1:0]         wave_q  [SEGS];
  logic [1:0]         wave_d  [SEGS];
  logic [FTW_W-1:0]   ftw_q   [SEGS];
  logic [FTW_W-1:0]   ftw_d   [SEGS];
  logic [DWELL_W-1:0] dwell_q [SEGS];
  logic [DWELL_W-1:0] dwell_d [SEGS];

  always_comb begin
    wave_d  = wave_q;
    ftw_d   = ftw_q;
    dwell_d = dwell_q;
    if (we) begin
      wave_d[waddr]  = wdat_wave;
      ftw_d[waddr]   = wdat_ftw;
      dwell_d[waddr] = wdat_dwell;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEGS; i++) begin
        wave_q[i]  <= WAVE_MUTE;
        ftw_q[i]   <= '0;
        dwell_q[i] <= '0;
      end
    end else begin
      wave_q  <= wave_d;
      ftw_q   <= ftw_d;
      dwell_q <= dwell_d;
    end
  end

  assign rd_wave  = wave_q[raddr];
  assign rd_ftw   = ftw_q[raddr];
  assign rd_dwell = dwell_q[raddr];

endmodule

// File: rtl/awg_seq_ctrl.sv
// AWG sequencer: steps through table segments, each held max(dwell,1) cycles, driving the DDS.
// All outputs registered; a new segment appears the cycle after its predecessor's count hits 0.
module awg_seq_ctrl
  import awg_seq_ctrl_pkg::*;
#(
  parameter int SEGS    = 8,
  parameter int FTW_W   = 14,
  parameter int DWELL_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(SEGS)-1:0]  cfg_addr,
  input  logic [1:0]               cfg_wave,
  input  logic [FTW_W-1:0]         cfg_ftw,
  input  logic [DWELL_W-1:0]       cfg_dwell,
  output logic                     cfg_err,
  input  logic                     start,
  input  logic                     stop,
  input  logic [$clog2(SEGS)-1:0]  last_seg,
  input  logic                     loop_en,
  output logic [1:0]               wave_sel,
  output logic [FTW_W-1:0]         ftw,
  output logic                     seg_strobe,
  output logic [$clog2(SEGS)-1:0]  seg_idx,
  output logic                     running,
  output logic                     done
);

  localparam int AW = $clog2(SEGS);

  seq_state_t         state_q, state_d;
  logic [1:0]         wave_sel_q, wave_sel_d;
  logic [FTW_W-1:0]   ftw_q, ftw_d;
  logic [AW-1:0]      seg_idx_q, seg_idx_d;
  logic               seg_strobe_q, seg_strobe_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]      last_q, last_d;
  logic               loop_q, loop_d;

  logic [AW-1:0]      rd_addr;
  logic [1:0]         rd_wave;
  logic [FTW_W-1:0]   rd_ftw;
  logic [DWELL_W-1:0] rd_dwell;
  logic               load_seg;
  logic               go_idle;
  logic               tbl_we;

  // The table is frozen while a sequence plays so the active segment can never change under us.
  assign tbl_we = cfg_we && (state_q == ST_IDLE);

  awg_seg_table #(
    .SEGS    (SEGS),
    .FTW_W   (FTW_W),
    .DWELL_W (DWELL_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .we         (tbl_we),
    .waddr      (cfg_addr),
    .wdat_wave  (cfg_wave),
    .wdat_ftw   (cfg_ftw),
    .wdat_dwell (cfg_dwell),
    .raddr      (rd_addr),
    .rd_wave    (rd_wave),
    .rd_ftw     (rd_ftw),
    .rd_dwell   (rd_dwell)
  );

  always_comb begin
    state_d      = state_q;
    wave_sel_d   = wave_sel_q;
    ftw_d        = ftw_q;
    seg_idx_d    = seg_idx_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    loop_d       = loop_q;
    seg_strobe_d = 1'b0;
    done_d       = 1'b0;
    cfg_err_d    = cfg_we && (state_q == ST_RUN);
    rd_addr      = '0;
    load_seg     = 1'b0;
    go_idle      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          load_seg = 1'b1;
          last_d   = last_seg;
          loop_d   = loop_en;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (cnt_q == '0) begin
          if (seg_idx_q != last_q) begin
            rd_addr  = seg_idx_q + 1'b1;
            load_seg = 1'b1;
          end else if (loop_q) begin
            load_seg = 1'b1;
          end else begin
            go_idle = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter holds remaining cycles after this one, so dwell 0 and 1 both give a single cycle.
    if (load_seg) begin
      wave_sel_d   = rd_wave;
      ftw_d        = rd_ftw;
      seg_idx_d    = rd_addr;
      cnt_d        = (rd_dwell == '0) ? '0 : rd_dwell - 1'b1;
      seg_strobe_d = 1'b1;
    end

    if (go_idle) begin
      state_d    = ST_IDLE;
      wave_sel_d = WAVE_MUTE;
      ftw_d      = '0;
      seg_idx_d  = '0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wave_sel_q   <= WAVE_MUTE;
      ftw_q        <= '0;
      seg_idx_q    <= '0;
      seg_strobe_q <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      cnt_q        <= '0;
      last_q       <= '0;
      loop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wave_sel_q   <= wave_sel_d;
      ftw_q        <= ftw_d;
      seg_idx_q    <= seg_idx_d;
      seg_strobe_q <= seg_strobe_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      loop_q       <= loop_d;
    end
  end

  assign wave_sel   = wave_sel_q;
  assign ftw        = ftw_q;
  assign seg_idx    = seg_idx_q;
  assign seg_strobe = seg_strobe_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;
  assign running    = (state_q == ST_RUN);

endmodule
